eth_fifo_frame_reader: RTL and testbench

//  Consumer side of the 9-bit Ethernet frame FIFO. Word = {last, byte[7:0]}.

---
 rtl/eth_fifo_pkg.sv | 14 +
 rtl/eth_pending_frame_cnt.sv | 37 +++
 rtl/eth_fifo_frame_reader.sv | 118 +++++++++++
 tb/tb_eth_fifo_frame_reader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_fifo_pkg.sv
// Shared types and constants for the Ethernet frame FIFO consumer path.
package eth_fifo_pkg;

    localparam int DATA_WIDTH  = 9;
    localparam int LAST_BIT    = 8;
    localparam int IFG_DEFAULT = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2
    } rd_state_t;

endpackage

// File: rtl/eth_pending_frame_cnt.sv
// Up/down saturating counter of frames committed to the FIFO but not yet started.
// Simultaneous inc and dec leave the count unchanged; an inc at full scale is dropped and flagged.
module eth_pending_frame_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         nonzero_o,
    output logic         ovf_o
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && count_q != CNT_MAX)
            count_d = count_q + 1'b1;
        else if (dec_i && !inc_i && count_q != '0)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count_o   = count_q;
    assign nonzero_o = (count_q != '0);
    // Single-cycle pulse; the owner decides whether it is sticky.
    assign ovf_o     = inc_i & ~dec_i & (count_q == CNT_MAX);

endmodule

// File: rtl/eth_fifo_frame_reader.sv
// Pops committed frames from a show-ahead FIFO onto a byte stream, then forces an inter-frame gap.
// Optional ETH_FRAME_READER_STATS_EN adds frame-count and last-frame-length outputs.
module eth_fifo_frame_reader #(
    parameter int DATA_WIDTH = 9,
    parameter int PEND_W     = 8,
    parameter int IFG_CYCLES = eth_fifo_pkg::IFG_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_commit,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_ren,
    output logic [7:0]            m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  busy,
    output logic                  err_ovf,
    output logic                  err_unf
`ifdef ETH_FRAME_READER_STATS_EN
    ,
    output logic [31:0]           stat_frames,
    output logic [15:0]           stat_len
`endif
);

    import eth_fifo_pkg::*;

    localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(IFG_CYCLES - 1);

    rd_state_t      state_q;
    logic [GW-1:0]  gap_q;
    logic           err_ovf_q, err_unf_q;
    logic           beat, eof_beat, start;
    logic           pend_nz, pend_ovf;
    logic [PEND_W-1:0] pend_count;

    assign start    = (state_q == IDLE) & pend_nz;
    assign m_tvalid = (state_q == STREAM) & ~fifo_empty;
    assign beat     = m_tvalid & m_tready;
    assign eof_beat = beat & fifo_dout[DATA_WIDTH-1];
    assign fifo_ren = beat;
    // Data is qualified by valid so every output reads 0 while idle or in reset.
    assign m_tdata  = m_tvalid ? fifo_dout[7:0] : 8'h00;
    assign m_tlast  = fifo_dout[DATA_WIDTH-1] & m_tvalid;
    assign busy     = (state_q != IDLE);
    assign err_ovf  = err_ovf_q;
    assign err_unf  = err_unf_q;

    eth_pending_frame_cnt #(.W(PEND_W)) u_pend (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (frame_commit),
        .dec_i     (start),
        .count_o   (pend_count),
        .nonzero_o (pend_nz),
        .ovf_o     (pend_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gap_q     <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            if (pend_ovf) err_ovf_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (pend_nz) state_q <= STREAM;
                end
                STREAM: begin
                    // A committed frame must be fully present; an empty FIFO here means lost data.
                    if (fifo_empty) begin
                        err_unf_q <= 1'b1;
                    end else if (eof_beat) begin
                        state_q <= GAP;
                        gap_q   <= GAP_LOAD;
                    end
                end
                GAP: begin
                    if (gap_q == '0) state_q <= IDLE;
                    else             gap_q   <= gap_q - 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ETH_FRAME_READER_STATS_EN
    logic [31:0] frames_q;
    logic [15:0] len_q, cur_len_q, cur_len_inc;

    assign cur_len_inc = (cur_len_q == 16'hFFFF) ? cur_len_q : cur_len_q + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_q  <= '0;
            len_q     <= '0;
            cur_len_q <= '0;
        end else if (beat) begin
            if (eof_beat) begin
                frames_q  <= frames_q + 32'd1;
                len_q     <= cur_len_inc;
                cur_len_q <= '0;
            end else begin
                cur_len_q <= cur_len_inc;
            end
        end
    end

    assign stat_frames = frames_q;
    assign stat_len    = len_q;
`endif

endmodule

// File: tb/tb_eth_fifo_frame_reader.sv
// Directed bench for eth_fifo_frame_reader with a behavioural show-ahead FIFO on its input.
module tb_eth_fifo_frame_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_commit = 1'b0;
    logic [8:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_ren;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready = 1'b0;
    logic       m_tlast;
    logic       busy;
    logic       err_ovf;
    logic       err_unf;
`ifdef ETH_FRAME_READER_STATS_EN
    logic [31:0] stat_frames;
    logic [15:0] stat_len;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Show-ahead FIFO model
    logic [8:0] mem [0:1023];
    logic [9:0] wp = '0;
    logic [9:0] rp = '0;
    logic       wr_en = 1'b0;
    logic [8:0] wr_data = '0;
    logic       fifo_clr = 1'b0;

    assign fifo_empty = (wp == rp);
    assign fifo_dout  = mem[rp];

    always @(posedge clk) begin
        if (wr_en) begin
            mem[wp] <= wr_data;
            wp      <= wp + 10'd1;
        end
        if (fifo_clr)      rp <= wp;
        else if (fifo_ren) rp <= rp + 10'd1;
    end

    eth_fifo_frame_reader #(.DATA_WIDTH(9), .PEND_W(8), .IFG_CYCLES(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_commit (frame_commit),
        .fifo_dout    (fifo_dout),
        .fifo_empty   (fifo_empty),
        .fifo_ren     (fifo_ren),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .busy         (busy),
        .err_ovf      (err_ovf),
        .err_unf      (err_unf)
`ifdef ETH_FRAME_READER_STATS_EN
        ,
        .stat_frames  (stat_frames),
        .stat_len     (stat_len)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [8:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        cyc();
        wr_en   = 1'b0;
    endtask

    task automatic commit();
        frame_commit = 1'b1;
        cyc();
        frame_commit = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        fifo_clr = 1'b1;
        cyc();
        cyc();
        rst      = 1'b0;
        fifo_clr = 1'b0;
        cyc();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            cyc();
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int seen;
        int idle;

        // Test 1: three-byte frame, then exactly 12 GAP cycles
        do_reset();
        chk("rst_tvalid", {31'd0, m_tvalid}, 0);
        chk("rst_ren",    {31'd0, fifo_ren}, 0);
        chk("rst_busy",   {31'd0, busy},     0);
        chk("rst_ovf",    {31'd0, err_ovf},  0);
        chk("rst_unf",    {31'd0, err_unf},  0);
        chk("rst_pend",   32'(dut.pend_count), 0);
        m_tready = 1'b1;
        push(9'h011); push(9'h022); push(9'h133);
        chk("t1_nocommit", {31'd0, m_tvalid}, 0);
        commit();
        chk("t1_latency", {31'd0, m_tvalid}, 0);
        cyc();
        chk("t1_v0",  {31'd0, m_tvalid}, 1);
        chk("t1_d0",  {24'd0, m_tdata}, 32'h11);
        chk("t1_l0",  {31'd0, m_tlast}, 0);
        chk("t1_r0",  {31'd0, fifo_ren}, 1);
        cyc();
        chk("t1_d1",  {24'd0, m_tdata}, 32'h22);
        cyc();
        chk("t1_d2",  {24'd0, m_tdata}, 32'h33);
        chk("t1_l2",  {31'd0, m_tlast}, 1);
        for (int i = 0; i < 12; i++) begin
            cyc();
            chk("t1_gap_tvalid", {31'd0, m_tvalid}, 0);
        end
        chk("t1_gap_busy", {31'd0, busy}, 1);
        cyc();
        chk("t1_idle_busy", {31'd0, busy}, 0);
`ifdef ETH_FRAME_READER_STATS_EN
        chk("t1_stat_frames", stat_frames, 1);
        chk("t1_stat_len", {16'd0, stat_len}, 3);
`endif

        // Test 2: data in FIFO without commit must not stream
        push(9'h0A0); push(9'h0A1); push(9'h0A2); push(9'h0A3); push(9'h1A4);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (m_tvalid) seen++;
            cyc();
        end
        chk("t2_no_tvalid", 32'(seen), 0);
        commit();
        chk("t2_latency", {31'd0, m_tvalid}, 0);
        cyc();
        chk("t2_start", {31'd0, m_tvalid}, 1);
        chk("t2_d0", {24'd0, m_tdata}, 32'hA0);
        for (int k = 1; k < 5; k++) begin
            cyc();
            chk("t2_dk", {24'd0, m_tdata}, 32'hA0 + 32'(k));
        end
        chk("t2_last", {31'd0, m_tlast}, 1);
        wait_idle("t2_idle");

        // Test 3: backpressure 1,0,0,1
        push(9'h0C1); push(9'h0C2); push(9'h0C3); push(9'h1C4);
        commit();
        cyc();
        chk("t3_d0", {24'd0, m_tdata}, 32'hC1);
        chk("t3_r0", {31'd0, fifo_ren}, 1);
        cyc();
        m_tready = 1'b0; #1;
        chk("t3_d1_hold", {24'd0, m_tdata}, 32'hC2);
        chk("t3_r1", {31'd0, fifo_ren}, 0);
        cyc();
        chk("t3_d2_hold", {24'd0, m_tdata}, 32'hC2);
        chk("t3_v2", {31'd0, m_tvalid}, 1);
        chk("t3_r2", {31'd0, fifo_ren}, 0);
        cyc();
        m_tready = 1'b1; #1;
        chk("t3_d3", {24'd0, m_tdata}, 32'hC2);
        chk("t3_r3", {31'd0, fifo_ren}, 1);
        cyc();
        chk("t3_d4", {24'd0, m_tdata}, 32'hC3);
        cyc();
        chk("t3_d5", {24'd0, m_tdata}, 32'hC4);
        chk("t3_l5", {31'd0, m_tlast}, 1);
        chk("t3_unf", {31'd0, err_unf}, 0);
        wait_idle("t3_idle");

        // Test 4: second commit lands on the IDLE->STREAM cycle
        push(9'h0D1); push(9'h1D2); push(9'h0E1); push(9'h1E2);
        frame_commit = 1'b1;
        cyc();
        cyc();
        frame_commit = 1'b0;
        chk("t4_pend", 32'(dut.pend_count), 1);
        chk("t4_dA0", {24'd0, m_tdata}, 32'hD1);
        cyc();
        chk("t4_dA1", {24'd0, m_tdata}, 32'hD2);
        chk("t4_lA1", {31'd0, m_tlast}, 1);
        idle = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (m_tvalid) break;
            idle++;
        end
        // 12 GAP cycles plus the IDLE cycle that launches the next frame
        chk("t4_gap", 32'(idle), 13);
        chk("t4_dB0", {24'd0, m_tdata}, 32'hE1);
        chk("t4_pend_end", 32'(dut.pend_count), 0);
        cyc();
        chk("t4_dB1", {24'd0, m_tdata}, 32'hE2);
        cyc();
`ifdef ETH_FRAME_READER_STATS_EN
        chk("t4_stat_frames", stat_frames, 5);
        chk("t4_stat_len", {16'd0, stat_len}, 2);
`endif
        wait_idle("t4_idle");

        // Test 5: saturate pending; the first commit is consumed by the start, so 256 reach 255
        frame_commit = 1'b1;
        repeat (256) cyc();
        frame_commit = 1'b0;
        chk("t5_pend_full", 32'(dut.pend_count), 255);
        chk("t5_ovf_clear", {31'd0, err_ovf}, 0);
        chk("t5_unf", {31'd0, err_unf}, 1);
        chk("t5_tvalid", {31'd0, m_tvalid}, 0);
        commit();
        chk("t5_ovf", {31'd0, err_ovf}, 1);
        chk("t5_pend_sat", 32'(dut.pend_count), 255);

        // Test 6: reset after two of six bytes
        do_reset();
        push(9'h0F1); push(9'h0F2); push(9'h0F3); push(9'h0F4); push(9'h0F5); push(9'h1F6);
        commit();
        cyc();
        chk("t6_d0", {24'd0, m_tdata}, 32'hF1);
        cyc();
        chk("t6_d1", {24'd0, m_tdata}, 32'hF2);
        cyc();
        chk("t6_d2", {24'd0, m_tdata}, 32'hF3);
        rst      = 1'b1;
        fifo_clr = 1'b1;
        #1;
        chk("t6_tvalid", {31'd0, m_tvalid}, 0);
        chk("t6_tdata",  {24'd0, m_tdata}, 0);
        chk("t6_tlast",  {31'd0, m_tlast}, 0);
        chk("t6_ren",    {31'd0, fifo_ren}, 0);
        chk("t6_busy",   {31'd0, busy}, 0);
        chk("t6_ovf",    {31'd0, err_ovf}, 0);
        chk("t6_unf",    {31'd0, err_unf}, 0);
        chk("t6_pend",   32'(dut.pend_count), 0);
`ifdef ETH_FRAME_READER_STATS_EN
        chk("t6_stat_frames", stat_frames, 0);
        chk("t6_stat_len", {16'd0, stat_len}, 0);
`endif
        cyc();
        rst      = 1'b0;
        fifo_clr = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (m_tvalid || busy) seen++;
        end
        chk("t6_quiet", 32'(seen), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
